// File: rtl/line_mem_arbiter.sv
// Arbiter sharing the single-port line memory between core load/store and host readout.
// Optional perf counters are enabled by defining LINE_MEM_ARB_PERF_EN.
module line_mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_core_re,
    input  logic                  i_core_we,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wr_data,
    output logic                  o_core_stall,
    output logic [DATA_WIDTH-1:0] o_core_rd_data,
    output logic                  o_core_rd_vld,
    input  logic                  i_host_req,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    output logic                  o_host_gnt,
    output logic [DATA_WIDTH-1:0] o_host_rd_data,
    output logic                  o_host_rd_vld,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
`ifdef LINE_MEM_ARB_PERF_EN
    output logic [15:0]           o_conflict_cnt,
    output logic [15:0]           o_force_cnt,
`endif
    output logic                  o_err
);

    // Handshake: a request is accepted in the cycle it is presented and granted
    // (core: ~o_core_stall, host: o_host_gnt); refused requests are re-presented
    // unchanged. Read data is valid for exactly one cycle, one cycle after the grant.

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       core_act;
    logic       force_host;
    logic       core_gnt;
    logic       host_gnt;
    logic [3:0] wait_cnt;
    logic       core_inflight;
    logic       host_inflight;

    assign core_act   = i_core_re | i_core_we;
    assign force_host = i_host_req & (wait_cnt == LIMIT);

    always_comb begin
        core_gnt      = 1'b0;
        host_gnt      = 1'b0;
        o_core_stall  = 1'b0;
        o_mem_re      = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wr_data = '0;
        if (force_host) begin
            host_gnt     = 1'b1;
            o_core_stall = core_act;
        end else if (core_act) begin
            core_gnt = 1'b1;
        end else if (i_host_req) begin
            host_gnt = 1'b1;
        end
        if (core_gnt) begin
            // A simultaneous load+store is flagged as an error and executed as a store.
            o_mem_we      = i_core_we;
            o_mem_re      = i_core_re & ~i_core_we;
            o_mem_addr    = i_core_addr;
            o_mem_wr_data = i_core_wr_data;
        end else if (host_gnt) begin
            o_mem_re   = 1'b1;
            o_mem_addr = i_host_addr;
        end
    end

    assign o_host_gnt = host_gnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt      <= '0;
            core_inflight <= 1'b0;
            host_inflight <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            core_inflight <= core_gnt & i_core_re & ~i_core_we;
            host_inflight <= host_gnt;
            if (host_gnt || !i_host_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (i_core_re && i_core_we) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_core_rd_vld  = core_inflight;
    assign o_host_rd_vld  = host_inflight;
    assign o_core_rd_data = core_inflight ? i_mem_rd_data : '0;
    assign o_host_rd_data = host_inflight ? i_mem_rd_data : '0;

`ifdef LINE_MEM_ARB_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_conflict_cnt <= '0;
            o_force_cnt    <= '0;
        end else begin
            if (core_act && i_host_req && o_conflict_cnt != 16'hFFFF) begin
                o_conflict_cnt <= o_conflict_cnt + 16'd1;
            end
            if (force_host && o_force_cnt != 16'hFFFF) begin
                o_force_cnt <= o_force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares the single-port line memory between the core datapath (load/store) and the external host read channel, which is used for result readout.
- Core traffic has priority. A starvation counter guarantees the host a slot within STARVE_LIMIT cycles.
- Sits between the core's load_en/store_en/ALUResult/pop-window signals and the line memory instance, and drives the top-level line-memory read channel.

Parameters:
- ADDR_WIDTH, 8, line memory address width.
- DATA_WIDTH, 32, line memory word width.
- STARVE_LIMIT, 4, maximum number of consecutive cycles a pending host request may be refused; legal range 1..15.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous reset, active-high
- i_core_re  input  1  core load request
- i_core_we  input  1  core store request
- i_core_addr  input  ADDR_WIDTH  core address
- i_core_wr_data  input  DATA_WIDTH  core store data
- o_core_stall  output  1  core request refused this cycle; core holds its request
- o_core_rd_data  output  DATA_WIDTH  core load data
- o_core_rd_vld  output  1  core load data valid
- i_host_req  input  1  host read request (level)
- i_host_addr  input  ADDR_WIDTH  host read address
- o_host_gnt  output  1  host request accepted this cycle
- o_host_rd_data  output  DATA_WIDTH  host read data
- o_host_rd_vld  output  1  host read data valid
- o_mem_re  output  1  memory read enable
- o_mem_we  output  1  memory write enable
- o_mem_addr  output  ADDR_WIDTH  memory address
- o_mem_wr_data  output  DATA_WIDTH  memory write data
- i_mem_rd_data  input  DATA_WIDTH  memory read data, valid one cycle after o_mem_re
- o_err  output  1  sticky protocol error

Behaviour:
- Reset (i_rst=1, asynchronous) clears the following, and all registered outputs are 0 from assertion until release:
  - wait_cnt, in-flight tags, o_core_rd_vld, o_host_rd_vld and o_err.
- Reset mid-operation drops any in-flight read: no vld pulse follows the reset.
- Grant per cycle is combinational.
  - core_act = i_core_re | i_core_we.
  - force = i_host_req & (wait_cnt == STARVE_LIMIT).
  - If force: host granted, o_core_stall = core_act.
  - Else if core_act: core granted, o_core_stall = 0.
  - Else if i_host_req: host granted.
  - o_host_gnt = host granted.
- Memory drive follows the grant, combinationally in the same cycle.
  - Core granted: o_mem_we = i_core_we; o_mem_re = i_core_re & ~i_core_we; o_mem_addr = i_core_addr; o_mem_wr_data = i_core_wr_data.
  - Host granted: o_mem_re = 1; o_mem_addr = i_host_addr.
  - Otherwise: o_mem_re = o_mem_we = 0. o_mem_addr and o_mem_wr_data are 0 whenever nothing is granted.
- Read return, latency 1.
  - Registered tags core_inflight and host_inflight are set on the cycle the respective read is granted.
  - Next cycle the matching o_*_rd_vld = 1 for one cycle; o_*_rd_data = i_mem_rd_data, passed through.
  - The non-matching rd_data output holds 0.
- Back-to-back reads are allowed every cycle. Host holding i_host_req high gets one gnt per accepted read.
- Starvation counter wait_cnt, 4 bits.
  - Increments when i_host_req & ~o_host_gnt.
  - Saturates at STARVE_LIMIT.
  - Cleared when o_host_gnt = 1 or i_host_req = 0.
- Error: i_core_re & i_core_we in the same cycle sets o_err. Cleared only by reset. The access is treated as a write.
- Stalled core request: no memory access, no vld; the core repeats the request next cycle.

Optional Feature:
- Macro LINE_MEM_ARB_PERF_EN.
- When defined, adds:
  - o_conflict_cnt: 16-bit counter of cycles with core_act & i_host_req.
  - o_force_cnt: 16-bit counter of forced host grants.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Core store addr 8'h10 data 32'hDEADBEEF, then core load addr 8'h10 -> o_mem_we pulse; load gives o_core_rd_vld=1 one cycle later with data 32'hDEADBEEF; o_core_stall=0 throughout.
- Host-only read addr 8'h10 with core idle -> o_host_gnt=1 same cycle; o_host_rd_vld=1 next cycle with 32'hDEADBEEF.
- STARVE_LIMIT=4, core loads every cycle, host req held from cycle 0:
  - host refused cycles 0–3; gnt at cycle 4 with o_core_stall=1 at cycle 4;
  - host vld at cycle 5; core resumes at cycle 5.
- Alternate core reads and host reads back-to-back -> every vld lands exactly one cycle after its grant on the correct channel; never both vld in one cycle.
- i_core_re=i_core_we=1 at addr 8'h20 data 5 -> write performed, o_err=1 stays set until i_rst pulse.
- Assert i_rst the cycle after a host grant -> no o_host_rd_vld; wait_cnt=0, o_err=0 after release.
